// File: rtl/uart_regfile_mc.sv
// Multi-channel UART register file: CTRL/BAUD/STATUS/IRQ_EN per channel, two independent read ports.
// Define UART_RF_IRQ_EN to build the IRQ_EN registers and irq outputs; otherwise irq is tied low.
module uart_regfile_mc #(
  parameter int N_CH = 2,
  parameter int READ_LATENCY = 0,
  localparam int ADDR_W = $clog2(N_CH) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [15:0]          wr_data,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [15:0]          rd_data_a,
  output logic [15:0]          rd_data_b,
  output logic                 rd_valid_a,
  output logic                 rd_valid_b,
  input  logic [N_CH-1:0]      uart_busy,
  input  logic [2*N_CH-1:0]    uart_error,
  input  logic [N_CH-1:0]      update_ok,
  output logic [N_CH-1:0]      uart_enable,
  output logic [3*N_CH-1:0]    uart_mode,
  output logic [16*N_CH-1:0]   uart_rate,
  output logic [N_CH-1:0]      irq
);

  localparam logic [15:0] BAUD_RST = 16'h2580;

  if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
    $error("uart_regfile_mc: READ_LATENCY must be 0 or 1");
  end
  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("uart_regfile_mc: N_CH must be in 1..8");
  end

  logic [N_CH-1:0][3:0][15:0] reg_word;
  logic [1:0]                 wr_reg;
  logic [31:0]                wr_ch;

  assign wr_reg = wr_addr[1:0];
  assign wr_ch  = 32'(wr_addr) >> 2;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [3:0]  ctrl;
    logic [15:0] shadow;
    logic [15:0] active;
    logic        busy;
    logic        frame;
    logic        parity;
    logic        pending;
    logic        wr_sel;

    assign wr_sel = wr_en && (wr_ch == 32'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctrl    <= '0;
        shadow  <= BAUD_RST;
        active  <= BAUD_RST;
        busy    <= 1'b0;
        frame   <= 1'b0;
        parity  <= 1'b0;
        pending <= 1'b0;
      end else begin
        busy <= uart_busy[gi];
        if (wr_sel && wr_reg == 2'd0)
          ctrl <= wr_data[3:0];
        // A colliding BAUD write still promotes the old shadow and re-arms pending.
        if (update_ok[gi] && pending)
          active <= shadow;
        if (wr_sel && wr_reg == 2'd1) begin
          shadow  <= wr_data;
          pending <= 1'b1;
        end else if (update_ok[gi]) begin
          pending <= 1'b0;
        end
        // Error set takes priority over a simultaneous write-1-to-clear.
        if (uart_error[2*gi])
          frame <= 1'b1;
        else if (wr_sel && wr_reg == 2'd2 && wr_data[1])
          frame <= 1'b0;
        if (uart_error[2*gi+1])
          parity <= 1'b1;
        else if (wr_sel && wr_reg == 2'd2 && wr_data[2])
          parity <= 1'b0;
      end
    end

`ifdef UART_RF_IRQ_EN
    logic [1:0] irq_en;
    logic       irq_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        irq_en <= '0;
        irq_q  <= 1'b0;
      end else begin
        if (wr_sel && wr_reg == 2'd3)
          irq_en <= wr_data[1:0];
        irq_q <= |({parity, frame} & irq_en);
      end
    end

    assign irq[gi]         = irq_q;
    assign reg_word[gi][3] = {14'd0, irq_en};
`else
    assign irq[gi]         = 1'b0;
    assign reg_word[gi][3] = 16'd0;
`endif

    assign reg_word[gi][0] = {12'd0, ctrl};
    assign reg_word[gi][1] = active;
    assign reg_word[gi][2] = {12'd0, pending, parity, frame, busy};

    assign uart_enable[gi]          = ctrl[0];
    assign uart_mode[3*gi +: 3]     = ctrl[3:1];
    assign uart_rate[16*gi +: 16]   = active;
  end

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][15:0]       rd_word;
  logic [1:0]             rd_hit;

  assign rd_addr = {rd_addr_b, rd_addr_a};

  // Out-of-range channels match nothing and fall through to data 0 / valid 0.
  always_comb begin
    rd_word = '0;
    rd_hit  = '0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ((32'(rd_addr[p]) >> 2) == 32'(c)) begin
          rd_hit[p]  = 1'b1;
          rd_word[p] = reg_word[c][rd_addr[p][1:0]];
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_rd_reg
    logic [1:0][15:0] data_q;
    logic [1:0]       valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        data_q  <= rd_word;
        valid_q <= rd_hit;
      end
    end

    assign rd_data_a  = data_q[0];
    assign rd_data_b  = data_q[1];
    assign rd_valid_a = valid_q[0];
    assign rd_valid_b = valid_q[1];
  end else begin : g_rd_comb
    assign rd_data_a  = rd_word[0];
    assign rd_data_b  = rd_word[1];
    assign rd_valid_a = rd_hit[0];
    assign rd_valid_b = rd_hit[1];
  end

endmodule

// File: tb/tb_uart_regfile_mc.sv
// Scoreboard bench for uart_regfile_mc: a 2-channel combinational-read instance and a
// 3-channel registered-read instance (for out-of-range addresses and read latency).
module tb_uart_regfile_mc;

`ifdef UART_RF_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-channel, READ_LATENCY=0
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic [1:0]  uart_busy, update_ok, uart_enable, irq;
  logic [3:0]  uart_error;
  logic [5:0]  uart_mode;
  logic [31:0] uart_rate;

  // 3-channel, READ_LATENCY=1
  logic        m_wr_en;
  logic [3:0]  m_wr_addr;
  logic [15:0] m_wr_data;
  logic [3:0]  m_rd_addr_a, m_rd_addr_b;
  logic [15:0] m_rd_data_a, m_rd_data_b;
  logic        m_rd_valid_a, m_rd_valid_b;
  logic [2:0]  m_uart_busy, m_update_ok, m_uart_enable, m_irq;
  logic [5:0]  m_uart_error;
  logic [8:0]  m_uart_mode;
  logic [47:0] m_uart_rate;

  uart_regfile_mc #(.N_CH(2), .READ_LATENCY(0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b), .uart_busy(uart_busy),
    .uart_error(uart_error), .update_ok(update_ok), .uart_enable(uart_enable),
    .uart_mode(uart_mode), .uart_rate(uart_rate), .irq(irq)
  );

  uart_regfile_mc #(.N_CH(3), .READ_LATENCY(1)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_data(m_wr_data),
    .rd_addr_a(m_rd_addr_a), .rd_addr_b(m_rd_addr_b), .rd_data_a(m_rd_data_a),
    .rd_data_b(m_rd_data_b), .rd_valid_a(m_rd_valid_a), .rd_valid_b(m_rd_valid_b),
    .uart_busy(m_uart_busy), .uart_error(m_uart_error), .update_ok(m_update_ok),
    .uart_enable(m_uart_enable), .uart_mode(m_uart_mode), .uart_rate(m_uart_rate), .irq(m_irq)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("check %s: %h", tag, got);
    end
  endtask

  task automatic expect_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag   = tag;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic expect_pop(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check(e.tag, got, e.value);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [15:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic m_wr(input logic [3:0] addr, input logic [15:0] data);
    m_wr_en = 1'b1; m_wr_addr = addr; m_wr_data = data;
    tick();
    m_wr_en = 1'b0;
  endtask

  // Combinational read: result checked within the same cycle.
  task automatic rd(input string tag, input bit pb, input logic [2:0] addr,
                    input logic [15:0] d, input logic v);
    if (pb) rd_addr_b = addr; else rd_addr_a = addr;
    expect_push(tag, {15'd0, v, d});
    #1;
    if (pb) expect_pop({15'd0, rd_valid_b, rd_data_b});
    else    expect_pop({15'd0, rd_valid_a, rd_data_a});
  endtask

  // Registered read: result checked after the address-sampling edge.
  task automatic m_rd(input string tag, input bit pb, input logic [3:0] addr,
                      input logic [15:0] d, input logic v);
    if (pb) m_rd_addr_b = addr; else m_rd_addr_a = addr;
    expect_push(tag, {15'd0, v, d});
    tick();
    if (pb) expect_pop({15'd0, m_rd_valid_b, m_rd_data_b});
    else    expect_pop({15'd0, m_rd_valid_a, m_rd_data_a});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr_a = 0; rd_addr_b = 0;
    uart_busy = 0; uart_error = 0; update_ok = 0;
    m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_rd_addr_a = 4'd1; m_rd_addr_b = 0;
    m_uart_busy = 0; m_uart_error = 0; m_update_ok = 0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_m_read_a", {15'd0, m_rd_valid_a, m_rd_data_a}, 32'd0);
    rd("rst_ctrl0", 0, 3'd0, 16'h0000, 1'b1);
    rd("rst_baud1", 1, 3'd5, 16'h2580, 1'b1);
    check("rst_rate", uart_rate, 32'h2580_2580);
    check("rst_enable", 32'(uart_enable), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);

    // First edge after release must take the write.
    rst = 1'b0;
    wr(3'd0, 16'hFFF5);
    rd("ctrl0_first_write", 0, 3'd0, 16'h0005, 1'b1);
    check("mode0", 32'(uart_mode[2:0]), 32'd2);

    // No write bypass on combinational read.
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0003;
    rd("ctrl1_same_cycle", 0, 3'd4, 16'h0000, 1'b1);
    tick();
    wr_en = 1'b0;
    rd("ctrl1_next_cycle", 0, 3'd4, 16'h0003, 1'b1);
    check("enable_both", 32'(uart_enable), 32'd3);
    check("mode1", 32'(uart_mode[5:3]), 32'd1);

    // Shadowed BAUD update.
    wr(3'd5, 16'hC200);
    rd("baud1_active_old", 0, 3'd5, 16'h2580, 1'b1);
    rd("status1_pending", 1, 3'd6, 16'h0008, 1'b1);
    update_ok = 2'b10;
    tick();
    update_ok = 2'b00;
    check("rate1_updated", 32'(uart_rate[31:16]), 32'h0000_C200);
    rd("status1_cleared", 1, 3'd6, 16'h0000, 1'b1);
    rd("baud1_active_new", 0, 3'd5, 16'hC200, 1'b1);

    // BAUD write colliding with update_ok.
    wr(3'd1, 16'h2222);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111; update_ok = 2'b01;
    tick();
    wr_en = 1'b0; update_ok = 2'b00;
    rd("baud0_collide", 0, 3'd1, 16'h2222, 1'b1);
    rd("status0_collide", 1, 3'd2, 16'h0008, 1'b1);
    update_ok = 2'b01;
    tick();
    check("rate0_second_update", 32'(uart_rate[15:0]), 32'h0000_1111);
    rd("status0_no_pending", 1, 3'd2, 16'h0000, 1'b1);
    tick();
    update_ok = 2'b00;
    check("rate0_update_idle", 32'(uart_rate[15:0]), 32'h0000_1111);

    // Busy is registered.
    uart_busy = 2'b01;
    rd("busy_delay", 0, 3'd2, 16'h0000, 1'b1);
    tick();
    uart_busy = 2'b00;
    rd("busy_set", 0, 3'd2, 16'h0001, 1'b1);
    tick();

    // Sticky error bits and W1C.
    uart_error = 4'b0001;
    tick();
    uart_error = 4'b0000;
    rd("frame_set", 0, 3'd2, 16'h0002, 1'b1);
    wr(3'd2, 16'h0002);
    rd("frame_w1c", 0, 3'd2, 16'h0000, 1'b1);
    uart_error = 4'b0001;
    wr(3'd2, 16'h0002);
    uart_error = 4'b0000;
    rd("frame_set_wins", 0, 3'd2, 16'h0002, 1'b1);
    wr(3'd2, 16'h0000);
    rd("status_write_zero", 0, 3'd2, 16'h0002, 1'b1);
    uart_error = 4'b0010;
    tick();
    uart_error = 4'b0000;
    rd("parity_set", 0, 3'd2, 16'h0006, 1'b1);
    wr(3'd2, 16'hFFF6);
    rd("both_w1c", 0, 3'd2, 16'h0000, 1'b1);
    uart_error = 4'b0100;
    tick();
    uart_error = 4'b0000;
    rd("frame1_set", 1, 3'd6, 16'h0002, 1'b1);
    rd("frame0_untouched", 0, 3'd2, 16'h0000, 1'b1);
    wr(3'd6, 16'h0002);

    // Interrupt path.
    wr(3'd3, 16'hFFFF);
    rd("irq_en0", 0, 3'd3, {14'd0, IRQ_ON, IRQ_ON}, 1'b1);
    rd("irq_en1", 1, 3'd7, 16'h0000, 1'b1);
    uart_error = 4'b0001;
    tick();
    uart_error = 4'b0000;
    check("irq_lag", 32'(irq), 32'd0);
    tick();
    check("irq_set", 32'(irq), {31'd0, IRQ_ON});
    wr(3'd2, 16'h0002);
    check("irq_hold", 32'(irq), {31'd0, IRQ_ON});
    tick();
    check("irq_clear", 32'(irq), 32'd0);

    // Both ports on the same address.
    rd("dual_a", 0, 3'd5, 16'hC200, 1'b1);
    rd("dual_b", 1, 3'd5, 16'hC200, 1'b1);
    check("dual_equal", 32'(rd_data_a), 32'(rd_data_b));

    // Asynchronous reset mid-cycle with a pending shadow.
    wr(3'd0, 16'h000F);
    wr(3'd5, 16'h3333);
    check("enable_before_rst", 32'(uart_enable), 32'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_enable", 32'(uart_enable), 32'd0);
    check("async_rst_rate", uart_rate, 32'h2580_2580);
    check("async_rst_m_valid", 32'(m_rd_valid_a), 32'd0);
    tick();
    rst = 1'b0;
    update_ok = 2'b10;
    tick();
    update_ok = 2'b00;
    check("rst_discards_shadow", uart_rate, 32'h2580_2580);
    rd("status1_after_rst", 0, 3'd6, 16'h0000, 1'b1);

    // Registered reads and out-of-range channel on the 3-channel instance.
    m_rd("m_baud2", 0, 4'd9, 16'h2580, 1'b1);
    m_rd_addr_a = 4'd8;
    #1;
    check("m_latency_hold", 32'(m_rd_data_a), 32'h0000_2580);
    tick();
    check("m_latency_update", {15'd0, m_rd_valid_a, m_rd_data_a}, 32'h0001_0000);
    m_wr(4'd13, 16'h5555);
    m_wr(4'd12, 16'h000F);
    m_rd("m_oob_baud", 0, 4'd13, 16'h0000, 1'b0);
    m_rd("m_oob_ctrl", 1, 4'd12, 16'h0000, 1'b0);
    check("m_oob_rate", m_uart_rate[31:0], 32'h2580_2580);
    check("m_oob_rate2", 32'(m_uart_rate[47:32]), 32'h0000_2580);
    check("m_oob_enable", 32'(m_uart_enable), 32'd0);
    m_rd("m_status2", 0, 4'd10, 16'h0000, 1'b1);
    m_wr(4'd8, 16'h0003);
    m_rd("m_ctrl2_b", 1, 4'd8, 16'h0003, 1'b1);
    check("m_enable2", 32'(m_uart_enable), 32'd4);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_regfile_mc.md
UART_REGFILE_MC -- requirements
Module: uart_regfile_mc

Interface
REQ-001 SHALL have parameter N_CH, default 2, meaning number of UART channels (1..8).
REQ-002 SHALL have parameter READ_LATENCY, default 0, meaning read pipeline depth; only 0 or 1 is legal, and any other value is an elaboration error.
REQ-003 SHALL define ADDR_W = $clog2(N_CH)+2 as a localparam, with address = {channel, reg[1:0]} and reg 0=CTRL, 1=BAUD, 2=STATUS, 3=IRQ_EN.
REQ-004 SHALL have port: clk  input  1  single clock, all logic on the rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have ports: wr_en  in  1; wr_addr  in  ADDR_W; wr_data  in  16  (host write).
REQ-007 SHALL have ports: rd_addr_a, rd_addr_b  in  ADDR_W; rd_data_a, rd_data_b  out  16; rd_valid_a, rd_valid_b  out  1.
REQ-008 SHALL have ports: uart_busy  in  N_CH; uart_error  in  2*N_CH (bit pair [2c+1:2c] = {parity, frame}); update_ok  in  N_CH.
REQ-009 SHALL have ports: uart_enable  out  N_CH; uart_mode  out  3*N_CH; uart_rate  out  16*N_CH; irq  out  N_CH.

Function
REQ-010 SHALL treat an address as OOB when channel >= N_CH; OOB writes SHALL be ignored, and OOB reads SHALL return data 0 with valid 0.
REQ-011 CTRL: bits [3:0] SHALL be RW, with bit0 = enable and [3:1] = mode; bits [15:4] SHALL read 0 and ignore writes.
REQ-012 BAUD: a write SHALL load the channel shadow and set STATUS.pending; a read SHALL return the active value.
REQ-013 SHALL copy shadow to active and clear pending on update_ok[c] when pending=1; update_ok with pending=0 SHALL have no effect.
REQ-014 When a BAUD write and update_ok occur in the same cycle, active SHALL take the old shadow, shadow SHALL take the new data, and pending SHALL stay 1.
REQ-015 STATUS bit0 SHALL be busy, RO, registered from uart_busy[c] with 1-cycle delay.
REQ-016 STATUS bit1 (frame) and bit2 (parity) SHALL be sticky, set when the corresponding error input is 1, and cleared by writing 1 to that bit (W1C).
REQ-017 When an error set and a W1C occur in the same cycle on the same bit, set SHALL win.
REQ-018 STATUS bit3 SHALL be pending, RO; STATUS bits [15:4] SHALL read 0; writing 0s to STATUS SHALL have no effect.
REQ-019 IRQ_EN: bits [1:0] SHALL be RW enables for frame/parity; other bits SHALL read 0.
REQ-020 irq[c] SHALL be registered as |(STATUS[2:1] & IRQ_EN[1:0]) and SHALL reflect state 1 cycle after the status/enable change.
REQ-021 With READ_LATENCY=0, reads SHALL be combinational from stored state with no write bypass; a same-cycle write SHALL become visible the next cycle.
REQ-022 With READ_LATENCY=1, rd_data and rd_valid SHALL be registered and SHALL reflect stored state at the address-sampling edge.
REQ-023 rd_valid SHALL be 1 for in-range addresses.
REQ-024 uart_enable, uart_mode, and uart_rate for each channel SHALL be driven directly from active CTRL/BAUD state.
REQ-025 The two read ports SHALL be fully independent, and both reading the same address SHALL return identical data.

Reset
REQ-026 On rst=1, every channel SHALL immediately go to CTRL=0, shadow=active=9600 (0x2580), STATUS=0, IRQ_EN=0, irq=0.
REQ-027 On rst=1, registered read outputs (READ_LATENCY=1) SHALL be data 0 and valid 0.
REQ-028 Reset asserted mid-pending SHALL discard the shadow, with active remaining 9600.
REQ-029 Reset release SHALL be synchronous-safe: the first write SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-030 Macro UART_RF_IRQ_EN, when defined, SHALL build the IRQ_EN registers and irq logic per REQ-019/020.
REQ-031 When UART_RF_IRQ_EN is undefined, IRQ_EN SHALL read 0 and ignore writes, irq SHALL be tied to 0, and no IRQ flops SHALL exist; all other behaviour SHALL be unchanged.

Verification
REQ-032 N_CH=2: write BAUD ch1 = 115200&0xFFFF (0xC200), then read ch1 BAUD -> 0x2580 with pending=1; after update_ok[1] -> uart_rate[1]=0xC200 and pending=0.
REQ-033 BAUD write 0x1111 and update_ok in the same cycle after shadow=0x2222 -> active=0x2222, shadow=0x1111, pending=1.
REQ-034 Pulse uart_error[1:0]=01, then write STATUS ch0 = 0x0002 -> bit1 clears; repeat with error held during the W1C -> bit1 stays 1.
REQ-035 IRQ_EN ch0 = 0x1, then pulse the frame error -> irq[0]=1 one cycle after STATUS sets; W1C -> irq[0]=0 the next cycle; without the macro, irq stays 0.
REQ-036 N_CH=3: write/read addr channel=3 -> no state change, data 0, valid 0; READ_LATENCY=1 -> data appears one cycle after the address.
REQ-037 Assert rst asynchronously mid-cycle with CTRL=0xF -> uart_enable=0 and uart_rate=0x2580 before the next edge.
